// File: rtl/sb_1237_color_detect.sv
// Colour sensor sequencer: steps the photodiode filter through red, green and blue, then reports the strongest channel.
// Optional macro COLOR_VOTE_EN: commit a colour only when two consecutive decisions agree.
module sb_1237_color_detect #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter logic [13:0] NONE_THRESH  = 14'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  output logic        S2,
  output logic        S3,
  output logic [1:0]  color,
  output logic        color_valid
);

  localparam int unsigned DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  localparam logic [1:0] SEL_RED   = 2'd0;
  localparam logic [1:0] SEL_GREEN = 2'd1;
  localparam logic [1:0] SEL_BLUE  = 2'd2;
  localparam logic [1:0] DECIDE    = 2'd3;

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [DW-1:0] dwell_r;
  logic          dwell_done_s;
  logic [13:0]   r_cnt_r;
  logic [13:0]   g_cnt_r;
  logic [13:0]   b_cnt_r;
  logic [1:0]    dec_s;
  logic          update_s;

  // Smallest count is the highest frequency; ties go red > green > blue, zero means no signal.
  function automatic logic [1:0] pick_color(input logic [13:0] r, input logic [13:0] g,
                                            input logic [13:0] b);
    logic [13:0] min_v;
    logic [1:0]  pick;
    if ((r <= g) && (r <= b)) begin
      min_v = r;
      pick  = COL_RED;
    end else if (g <= b) begin
      min_v = g;
      pick  = COL_GREEN;
    end else begin
      min_v = b;
      pick  = COL_BLUE;
    end
    if ((r == 14'd0) || (g == 14'd0) || (b == 14'd0) || (min_v > NONE_THRESH)) begin
      pick = COL_NONE;
    end
    return pick;
  endfunction

  assign dwell_done_s = (dwell_r == DWELL_LAST);
  assign dec_s        = pick_color(r_cnt_r, g_cnt_r, b_cnt_r);

  // Next-state logic for the filter sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEL_RED:   if (dwell_done_s) state_nxt_s = SEL_GREEN; else state_nxt_s = SEL_RED;
      SEL_GREEN: if (dwell_done_s) state_nxt_s = SEL_BLUE;  else state_nxt_s = SEL_GREEN;
      SEL_BLUE:  if (dwell_done_s) state_nxt_s = DECIDE;    else state_nxt_s = SEL_BLUE;
      DECIDE:    state_nxt_s = SEL_RED;
      default:   state_nxt_s = SEL_RED;
    endcase
  end

  // State, dwell timer, channel latches and filter select outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= SEL_RED;
      dwell_r  <= {DW{1'b0}};
      r_cnt_r  <= 14'd0;
      g_cnt_r  <= 14'd0;
      b_cnt_r  <= 14'd0;
      {S2, S3} <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) dwell_r <= {DW{1'b0}};
      else                        dwell_r <= dwell_r + DW'(1);
      if (dwell_done_s && (state_r == SEL_RED))   r_cnt_r <= count;
      if (dwell_done_s && (state_r == SEL_GREEN)) g_cnt_r <= count;
      if (dwell_done_s && (state_r == SEL_BLUE))  b_cnt_r <= count;
      // Filter bits follow the state being entered so they line up with it; DECIDE keeps blue's 01.
      case (state_nxt_s)
        SEL_RED:   {S2, S3} <= 2'b00;
        SEL_GREEN: {S2, S3} <= 2'b11;
        SEL_BLUE:  {S2, S3} <= 2'b01;
        DECIDE:    {S2, S3} <= 2'b01;
        default:   {S2, S3} <= 2'b00;
      endcase
    end
  end

`ifdef COLOR_VOTE_EN
  logic [1:0] prev_dec_r;
  logic       prev_ok_r;

  // Remember the last decision; the first one after reset has nothing to agree with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_dec_r <= COL_NONE;
      prev_ok_r  <= 1'b0;
    end else if (state_r == DECIDE) begin
      prev_dec_r <= dec_s;
      prev_ok_r  <= 1'b1;
    end
  end

  assign update_s = (state_r == DECIDE) && prev_ok_r && (prev_dec_r == dec_s);
`else
  assign update_s = (state_r == DECIDE);
`endif

  // Colour result register with its one-cycle update strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color       <= COL_NONE;
      color_valid <= 1'b0;
    end else begin
      color_valid <= update_s;
      if (update_s) color <= dec_s;
    end
  end

endmodule

// File: tb/tb_sb_1237_color_detect.sv
// Self-checking bench for sb_1237_color_detect: directed rounds plus randomized rounds against a round-level model.
module tb_sb_1237_color_detect;

  localparam int D     = 8;
  localparam int ROUND = 3 * D + 1;
  localparam int TH    = 2000;

`ifdef COLOR_VOTE_EN
  localparam int NDIR = 6;
  int dr[NDIR]  = '{500, 900, 900, 900, 800, 800};
  int dg[NDIR]  = '{900, 800, 800, 800, 300, 300};
  int db[NDIR]  = '{1200, 300, 300, 300, 300, 300};
  int dc[NDIR]  = '{0, 0, 3, 3, 3, 2};
  int dv[NDIR]  = '{0, 0, 1, 1, 0, 1};
`else
  localparam int NDIR = 9;
  int dr[NDIR]  = '{500, 800, 300, 2500, 400, 2000, 2001, 16383, 300};
  int dg[NDIR]  = '{900, 300, 300, 2500, 400, 2000, 2001, 5, 300};
  int db[NDIR]  = '{1200, 300, 900, 2500, 0, 2000, 2001, 16383, 300};
  int dc[NDIR]  = '{1, 2, 1, 0, 0, 1, 0, 2, 1};
  int dv[NDIR]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] count = 14'd0;
  logic        S2, S3;
  logic [1:0]  color;
  logic        color_valid;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int cyc;
  int round_k;
  int rv, gv, bv;
  int lit_c, lit_v;
  bit lit_on;
  bit have_prev;
  logic [1:0] prev_dec;
  logic [1:0] exp_sel;
  logic [1:0] exp_color;
  logic       exp_valid;

  always #5 clk = ~clk;

  sb_1237_color_detect #(.DWELL_CYCLES(D), .NONE_THRESH(14'd2000)) dut (
    .clk(clk), .reset(reset), .count(count),
    .S2(S2), .S3(S3), .color(color), .color_valid(color_valid)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Minimum count wins, earliest channel among equals, none on zero or above threshold.
  function automatic logic [1:0] model_decide(input int r, input int g, input int b);
    int mn;
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    if (r == 0 || g == 0 || b == 0 || mn > TH) return 2'd0;
    if (r == mn) return 2'd1;
    if (g == mn) return 2'd2;
    return 2'd3;
  endfunction

  function automatic int rand_cnt();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 0;
      1: return 2000;
      2: return 2001;
      3: return 16383;
      default: return $urandom_range(1, 2500);
    endcase
  endfunction

  task automatic apply_decision();
    logic [1:0] d;
    d = model_decide(rv, gv, bv);
`ifdef COLOR_VOTE_EN
    if (have_prev && prev_dec == d) begin
      exp_color = d;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    prev_dec  = d;
    have_prev = 1'b1;
`else
    exp_color = d;
    exp_valid = 1'b1;
`endif
  endtask

  task automatic begin_cycle();
    int ph;
    ph = cyc % ROUND;
    exp_valid = 1'b0;
    if (ph == 0 && cyc > 0) begin
      apply_decision();
      if (lit_on) begin
        check("lit_color", color, lit_c[1:0]);
        check("lit_valid", color_valid, lit_v[0]);
      end
    end
    if (ph == 0) begin
      if (round_k < NDIR) begin
        rv = dr[round_k]; gv = dg[round_k]; bv = db[round_k];
        lit_c = dc[round_k]; lit_v = dv[round_k]; lit_on = 1'b1;
      end else begin
        lit_on = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          rv = rand_cnt(); gv = rand_cnt(); bv = rand_cnt();
          if ($urandom_range(0, 3) == 0) gv = rv;
          if ($urandom_range(0, 3) == 0) bv = gv;
        end
      end
      round_k++;
    end
    if (ph < D)          exp_sel = 2'b00;
    else if (ph < 2 * D) exp_sel = 2'b11;
    else                 exp_sel = 2'b01;
    if (round_k > NDIR && ph != D - 1 && ph != 2 * D - 1 && ph != 3 * D - 1)
      count = 14'($urandom_range(0, 16383));
    else if (ph < D)     count = 14'(rv);
    else if (ph < 2 * D) count = 14'(gv);
    else if (ph < 3 * D) count = 14'(bv);
    else                 count = 14'($urandom_range(0, 16383));
  endtask

  task automatic start_run();
    cyc = 0;
    round_k = 0;
    exp_color = 2'd0;
    have_prev = 1'b0;
    prev_dec = 2'd0;
    rv = 0; gv = 0; bv = 0;
    begin_cycle();
    check_en = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc++;
      begin_cycle();
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("S2S3", {S2, S3}, exp_sel);
      check("color", color, exp_color);
      check("color_valid", color_valid, exp_valid);
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_S2S3", {S2, S3}, 2'b00);
    check("rst_color", color, 2'b00);
    check("rst_valid", color_valid, 1'b0);
    #1;
    reset = 1'b0;
    start_run();
    // Abort a round 12 cycles in: outputs must clear in the same cycle.
    run_cycles(ROUND + 12);
    check_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_S2S3", {S2, S3}, 2'b00);
    check("midrst_color", color, 2'b00);
    check("midrst_valid", color_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    start_run();
    run_cycles(ROUND * (NDIR + 14) + 3);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
